vga_sync_gen: RTL

- Generates VGA raster timing: free-running h_counter/v_counter, HSYNC/VSYNC, blanking and the DAC pixel clock.
- Feeds the title-screen and game renderers. The renderers are combinational functions of h_counter/v_counter/troca and return R/G/B.
- Produces the sprite animation toggle troca.
- Owns the output register stage that aligns renderer colour with sync and blanks colour outside the visible area.

---
 rtl/vga_sync_gen.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//   VGA raster timing generator with DAC output register stage.
//   A clock divider produces a one-clk pixel strobe (pix_tick). Column and line
//   counters advance on that strobe, and a frame counter toggles the sprite
//   animation phase (troca) every TROCA_FRAMES frames. Renderer colour, sync
//   and blank are registered together on pix_tick from the pre-tick counter
//   values, so everything reaches the DAC pins with the same one-pixel delay.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset
//   R_in/G_in/B_in renderer colour for the current h_counter/v_counter
//   h_counter      current pixel column, 0..H_TOTAL-1
//   v_counter      current line, 0..V_TOTAL-1
//   video_on       1 inside the visible area (combinational from the counters)
//   pix_tick       one-clk pixel advance strobe
//   frame_tick     one-clk pulse on the last pixel of the frame
//   troca          animation phase toggle
//   VGA_R/G/B      registered colour to the DAC, zero outside the visible area
//   VGA_HS/VGA_VS  registered syncs, active low
//   VGA_BLANK_N    registered, 1 when visible
//   VGA_SYNC_N     constant 0
//   VGA_CLK        registered pixel clock to the DAC
// ---------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int CLK_DIV      = 2,
    parameter int H_VISIBLE    = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_VISIBLE    = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int TROCA_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] R_in,
    input  logic [7:0] G_in,
    input  logic [7:0] B_in,
    output logic [9:0] h_counter,
    output logic [9:0] v_counter,
    output logic       video_on,
    output logic       pix_tick,
    output logic       frame_tick,
    output logic       troca,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int FC_W    = (TROCA_FRAMES > 1) ? $clog2(TROCA_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(TROCA_FRAMES - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt_q,   div_cnt_d;
    logic [9:0]       h_cnt_q,     h_cnt_d;
    logic [9:0]       v_cnt_q,     v_cnt_d;
    logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic             troca_q,     troca_d;
    logic [7:0]       vga_r_q,     vga_r_d;
    logic [7:0]       vga_g_q,     vga_g_d;
    logic [7:0]       vga_b_q,     vga_b_d;
    logic             vga_hs_q,    vga_hs_d;
    logic             vga_vs_q,    vga_vs_d;
    logic             blank_n_q,   blank_n_d;
    logic             vga_clk_q,   vga_clk_d;

    logic pix_tick_s;
    logic frame_tick_s;
    logic video_on_s;
    logic in_hsync_s;
    logic in_vsync_s;

    // Strobes are forced low while reset is asserted so nothing downstream
    // sees a pixel advance during a reset cycle.
    assign pix_tick_s   = ~reset & (div_cnt_q == DIV_LAST);
    assign frame_tick_s = pix_tick_s & (h_cnt_q == H_LAST) & (v_cnt_q == V_LAST);
    assign video_on_s   = (h_cnt_q < H_VIS) & (v_cnt_q < V_VIS);
    assign in_hsync_s   = (h_cnt_q >= HS_START) & (h_cnt_q <= HS_END);
    assign in_vsync_s   = (v_cnt_q >= VS_START) & (v_cnt_q <= VS_END);

    // Next-state logic for the divider, raster counters and animation phase.
    always_comb begin
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        frame_cnt_d = frame_cnt_q;
        troca_d     = troca_q;

        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = {DIV_W{1'b0}};
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        // The DAC clock is high for the second half of each pixel, so the
        // register stage (updated when the divider wraps) changes on its fall.
        vga_clk_d = (div_cnt_d >= DIV_HALF);

        if (pix_tick_s) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 10'd0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = 10'd0;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end else begin
            h_cnt_d = h_cnt_q;
        end

        if (frame_tick_s) begin
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d = {FC_W{1'b0}};
                troca_d     = ~troca_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FC_W'(1);
            end
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // DAC register stage: captures colour/sync/blank for the pixel that is
    // ending, so all pins carry the same pixel one period later.
    always_comb begin
        vga_r_d   = vga_r_q;
        vga_g_d   = vga_g_q;
        vga_b_d   = vga_b_q;
        vga_hs_d  = vga_hs_q;
        vga_vs_d  = vga_vs_q;
        blank_n_d = blank_n_q;
        if (pix_tick_s) begin
            // Renderers OR sprites together, so porches must be forced black.
            vga_r_d   = video_on_s ? R_in : 8'h00;
            vga_g_d   = video_on_s ? G_in : 8'h00;
            vga_b_d   = video_on_s ? B_in : 8'h00;
            vga_hs_d  = ~in_hsync_s;
            vga_vs_d  = ~in_vsync_s;
            blank_n_d = video_on_s;
        end else begin
            blank_n_d = blank_n_q;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q   <= {DIV_W{1'b0}};
            h_cnt_q     <= 10'd0;
            v_cnt_q     <= 10'd0;
            frame_cnt_q <= {FC_W{1'b0}};
            troca_q     <= 1'b0;
            vga_r_q     <= 8'h00;
            vga_g_q     <= 8'h00;
            vga_b_q     <= 8'h00;
            vga_hs_q    <= 1'b1;
            vga_vs_q    <= 1'b1;
            blank_n_q   <= 1'b0;
            vga_clk_q   <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            troca_q     <= troca_d;
            vga_r_q     <= vga_r_d;
            vga_g_q     <= vga_g_d;
            vga_b_q     <= vga_b_d;
            vga_hs_q    <= vga_hs_d;
            vga_vs_q    <= vga_vs_d;
            blank_n_q   <= blank_n_d;
            vga_clk_q   <= vga_clk_d;
        end
    end

    assign h_counter   = h_cnt_q;
    assign v_counter   = v_cnt_q;
    assign video_on    = video_on_s;
    assign pix_tick    = pix_tick_s;
    assign frame_tick  = frame_tick_s;
    assign troca       = troca_q;
    assign VGA_R       = vga_r_q;
    assign VGA_G       = vga_g_q;
    assign VGA_B       = vga_b_q;
    assign VGA_HS      = vga_hs_q;
    assign VGA_VS      = vga_vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = vga_clk_q;

endmodule
